// File: rtl/max_pool_1_pkg.sv
// Geometry, BRAM constants and FSM encoding shared by the pool-1 stage
// and the max_16 comparator (which pool-2 also reuses).
package max_pool_1_pkg;
    localparam int DATA_SIZE    = 16;
    localparam int CONV1_DEEP   = 6;
    localparam int CONV1_OUTPUT = 28;
    localparam int POOL1_SIZE   = 2;
    localparam int POOL1_OUTPUT = CONV1_OUTPUT / POOL1_SIZE;

    localparam int CONV_ADDR_W = 13;
    localparam int POOL_ADDR_W = 11;

    localparam logic [CONV_ADDR_W-1:0] CONV1_RESULT_BASE = '0;
    localparam logic [POOL_ADDR_W-1:0] POOL1_RESULT_BASE = '0;

    // Every BRAM access owns a fixed 4-cycle slot: issue, two waits, capture.
    localparam int BRAM_CIRCLE = 4;

    localparam logic [CONV_ADDR_W-1:0] CONV_MAP_WORDS = CONV_ADDR_W'(CONV1_OUTPUT * CONV1_OUTPUT);
    localparam logic [CONV_ADDR_W-1:0] CONV_ROW_WORDS = CONV_ADDR_W'(CONV1_OUTPUT);
    localparam logic [POOL_ADDR_W-1:0] POOL_MAP_WORDS = POOL_ADDR_W'(POOL1_OUTPUT * POOL1_OUTPUT);
    localparam logic [POOL_ADDR_W-1:0] POOL_ROW_WORDS = POOL_ADDR_W'(POOL1_OUTPUT);

    typedef enum logic [4:0] {
        S_IDLE        = 5'b00001,
        S_CHECK       = 5'b00010,
        S_LOAD_WINDOW = 5'b00100,
        S_STORE       = 5'b01000,
        S_DONE        = 5'b10000
    } state_t;
endpackage

// File: rtl/max_pool_1_max16.sv
// Combinational signed max of two words; on a tie the first operand is kept.
module max_16
    import max_pool_1_pkg::*;
(
    input  logic signed [DATA_SIZE-1:0] i_keep,
    input  logic signed [DATA_SIZE-1:0] i_cand,
    output logic signed [DATA_SIZE-1:0] o_max
);
    assign o_max = (i_cand > i_keep) ? i_cand : i_keep;
endmodule

// File: rtl/max_pool_1.sv
// 2x2 stride-2 max pooling of the 6x28x28 conv-1 maps into 6x14x14 results,
// one BRAM read or write slot of four cycles at a time.
module max_pool_1
    import max_pool_1_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pool_1_en,
    input  logic [DATA_SIZE-1:0]   conv_result_bram_douta,
    output logic                   conv_result_bram_ena,
    output logic [CONV_ADDR_W-1:0] conv_result_bram_addra,
    output logic                   pool_result_bram_ena,
    output logic                   pool_result_bram_wea,
    output logic [POOL_ADDR_W-1:0] pool_result_bram_addra,
    output logic [DATA_SIZE-1:0]   pool_result_bram_dina,
    output logic                   pool_1_finish
);
    localparam logic [2:0] CH_END      = 3'(CONV1_DEEP);
    localparam logic [3:0] POS_LAST    = 4'(POOL1_OUTPUT - 1);
    localparam logic [1:0] CNT_LAST    = 2'(POOL1_SIZE * POOL1_SIZE - 1);
    localparam logic [1:0] CIRCLE_LAST = 2'(BRAM_CIRCLE - 1);

    state_t r_state, w_state_nxt;
    logic [2:0] r_channel, w_channel_nxt;
    logic [3:0] r_row, w_row_nxt, r_column, w_column_nxt;
    logic [1:0] r_count, w_count_nxt, r_circle, w_circle_nxt;
    logic signed [DATA_SIZE-1:0] r_max, w_max_nxt, w_max, w_douta;
    logic r_rd_ena, w_rd_ena_nxt, r_wr_ena, w_wr_ena_nxt, r_wr_wea, w_wr_wea_nxt;
    logic r_finish, w_finish_nxt;
    logic [CONV_ADDR_W-1:0] r_rd_addr, w_rd_addr_nxt, w_rd_addr, w_in_row, w_in_col;
    logic [POOL_ADDR_W-1:0] r_wr_addr, w_wr_addr_nxt, w_wr_addr;
    logic [DATA_SIZE-1:0]   r_wr_data, w_wr_data_nxt;

    assign w_douta = signed'(conv_result_bram_douta);

    max_16 u_max_16 (
        .i_keep (r_max),
        .i_cand (w_douta),
        .o_max  (w_max)
    );

    // count[1] selects the window row (dy), count[0] the window column (dx).
    assign w_in_row  = {8'd0, r_row, 1'b0} + {12'd0, r_count[1]};
    assign w_in_col  = {8'd0, r_column, 1'b0} + {12'd0, r_count[0]};
    assign w_rd_addr = CONV1_RESULT_BASE + {10'd0, r_channel} * CONV_MAP_WORDS
                     + w_in_row * CONV_ROW_WORDS + w_in_col;
    assign w_wr_addr = POOL1_RESULT_BASE + {8'd0, r_channel} * POOL_MAP_WORDS
                     + {7'd0, r_row} * POOL_ROW_WORDS + {7'd0, r_column};

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:        if (pool_1_en) w_state_nxt = S_CHECK;
            S_CHECK:       if (pool_1_en) w_state_nxt = (r_channel == CH_END) ? S_DONE : S_LOAD_WINDOW;
            S_LOAD_WINDOW: if (pool_1_en && r_circle == CIRCLE_LAST && r_count == CNT_LAST)
                               w_state_nxt = S_STORE;
            S_STORE:       if (pool_1_en && r_circle == CIRCLE_LAST) w_state_nxt = S_CHECK;
            S_DONE:        if (!pool_1_en) w_state_nxt = S_IDLE;
            default:       w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: every *_nxt starts from a hold default so no path through the case can infer a latch.
    always_comb begin
        w_channel_nxt = r_channel;  w_row_nxt    = r_row;     w_column_nxt = r_column;
        w_count_nxt   = r_count;    w_circle_nxt = r_circle;  w_max_nxt    = r_max;
        w_rd_ena_nxt  = r_rd_ena;   w_rd_addr_nxt = r_rd_addr;
        w_wr_ena_nxt  = r_wr_ena;   w_wr_wea_nxt = r_wr_wea;
        w_wr_addr_nxt = r_wr_addr;  w_wr_data_nxt = r_wr_data;
        w_finish_nxt  = r_finish;
        case (r_state)
            S_IDLE: if (pool_1_en) begin
                w_channel_nxt = '0; w_row_nxt = '0; w_column_nxt = '0;
                w_count_nxt   = '0; w_circle_nxt = '0; w_finish_nxt = 1'b0;
            end
            S_CHECK: if (pool_1_en) begin
                if (r_channel == CH_END) begin
                    w_rd_ena_nxt = 1'b0; w_wr_ena_nxt = 1'b0; w_wr_wea_nxt = 1'b0;
                    w_finish_nxt = 1'b1;
                end else begin
                    w_count_nxt = '0; w_circle_nxt = '0;
                end
            end
            S_LOAD_WINDOW: if (pool_1_en) begin
                w_circle_nxt = r_circle + 2'd1;
                if (r_circle == '0) begin
                    w_rd_ena_nxt  = 1'b1;
                    w_rd_addr_nxt = w_rd_addr;
                end
                if (r_circle == CIRCLE_LAST) begin
                    w_max_nxt   = (r_count == '0) ? w_douta : w_max;
                    w_count_nxt = r_count + 2'd1;
                    if (r_count == CNT_LAST) w_rd_ena_nxt = 1'b0;
                end
            end
            S_STORE: if (pool_1_en) begin
                w_circle_nxt = r_circle + 2'd1;
                if (r_circle == '0) begin
                    w_wr_ena_nxt  = 1'b1; w_wr_wea_nxt = 1'b1;
                    w_wr_addr_nxt = w_wr_addr;
                    w_wr_data_nxt = r_max;
                end
                if (r_circle == CIRCLE_LAST) begin
                    w_wr_ena_nxt = 1'b0; w_wr_wea_nxt = 1'b0;
                    if (r_column == POS_LAST) begin
                        w_column_nxt = '0;
                        if (r_row == POS_LAST) begin
                            w_row_nxt     = '0;
                            w_channel_nxt = r_channel + 3'd1;
                        end else begin
                            w_row_nxt = r_row + 4'd1;
                        end
                    end else begin
                        w_column_nxt = r_column + 4'd1;
                    end
                end
            end
            S_DONE: if (!pool_1_en) w_finish_nxt = 1'b0;
            default: begin
                w_rd_ena_nxt = 1'b0; w_wr_ena_nxt = 1'b0; w_wr_wea_nxt = 1'b0;
            end
        endcase
    end

    // NOTE: state registers take <= so all of them update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_channel <= '0; r_row <= '0; r_column <= '0; r_count <= '0; r_circle <= '0;
            r_max     <= '0; r_rd_ena <= 1'b0; r_rd_addr <= '0;
            r_wr_ena  <= 1'b0; r_wr_wea <= 1'b0; r_wr_addr <= '0; r_wr_data <= '0;
            r_finish  <= 1'b0;
        end else begin
            r_channel <= w_channel_nxt; r_row <= w_row_nxt; r_column <= w_column_nxt;
            r_count   <= w_count_nxt;   r_circle <= w_circle_nxt; r_max <= w_max_nxt;
            r_rd_ena  <= w_rd_ena_nxt;  r_rd_addr <= w_rd_addr_nxt;
            r_wr_ena  <= w_wr_ena_nxt;  r_wr_wea <= w_wr_wea_nxt;
            r_wr_addr <= w_wr_addr_nxt; r_wr_data <= w_wr_data_nxt;
            r_finish  <= w_finish_nxt;
        end
    end

    assign conv_result_bram_ena   = r_rd_ena;
    assign conv_result_bram_addra = r_rd_addr;
    assign pool_result_bram_ena   = r_wr_ena;
    assign pool_result_bram_wea   = r_wr_wea;
    assign pool_result_bram_addra = r_wr_addr;
    assign pool_result_bram_dina  = r_wr_data;
    assign pool_1_finish          = r_finish;
endmodule
